// File: rtl/uart_rx_pkg.sv
// Shared UART RX types: deserializer states, parity-type encoding, counter width helper.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic int cnt_w(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/uart_par_calc.sv
// Parity over the low i_len bits of a right-justified word; combinational, no flow control.
module uart_par_calc
  import uart_rx_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  localparam int CNT_W      = cnt_w(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic [CNT_W-1:0]      i_len,
  input  logic                  i_par_type,
  output logic                  o_par
);

  logic [DATA_WIDTH-1:0] w_mask;
  logic                  w_xor;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      w_mask[i] = (i < int'(i_len));
    end
  end

  assign w_xor = ^(i_word & w_mask);
  assign o_par = (i_par_type == PAR_ODD) ? ~w_xor : w_xor;

endmodule

// File: rtl/uart_rx_deserializer.sv
// Serial-to-parallel UART RX with runtime length/order/parity; P_DATA, par_err and
// data_valid appear one cycle after the final tick; no back-pressure, aborts on deser_en low.
module uart_rx_deserializer
  import uart_rx_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int EDGE_W     = 5,
  localparam int CNT_W      = cnt_w(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  deser_en,
  input  logic                  sampled_bit,
  input  logic [EDGE_W-1:0]     edge_cnt,
  input  logic [EDGE_W-1:0]     prescale,
  input  logic [3:0]            data_len,
  input  logic                  msb_first,
  input  logic                  par_en,
  input  logic                  par_type,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  busy,
  output logic [CNT_W-1:0]      bit_cnt
);

  rx_state_e             r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shreg, r_pdata;
  logic [CNT_W-1:0]      r_bit_cnt, r_len;
  logic                  r_msb, r_par_en, r_par_type, r_par_err;

  logic                  w_tick, w_idle, w_msb, w_par_en;
  logic [EDGE_W-1:0]     w_tick_edge;
  logic [CNT_W-1:0]      w_len_in, w_len, w_cnt_base, w_cnt_inc;
  logic [DATA_WIDTH-1:0] w_shreg_base, w_shreg_shift, w_word_fin, w_word_par;
  logic                  w_data_tick, w_last, w_par_tick, w_fin_data, w_par_exp;

  function automatic logic [DATA_WIDTH-1:0] align(input logic [DATA_WIDTH-1:0] sh,
                                                  input logic [CNT_W-1:0]      len,
                                                  input logic                  msb);
    return msb ? sh : (sh >> (CNT_W'(DATA_WIDTH) - len));
  endfunction

  // prescale of 0 wraps so the tick lands on edge_cnt all-ones
  assign w_tick_edge = prescale - EDGE_W'(1);
  assign w_tick      = deser_en && (edge_cnt == w_tick_edge);
  assign w_idle      = (r_state == IDLE);

  always_comb begin
    w_len_in = CNT_W'(data_len);
    if (data_len == 4'd0 || int'(data_len) > DATA_WIDTH) w_len_in = CNT_W'(DATA_WIDTH);
  end

  // In IDLE the live configuration applies, so a tick on the start cycle is bit 0
  assign w_len        = w_idle ? w_len_in  : r_len;
  assign w_msb        = w_idle ? msb_first : r_msb;
  assign w_par_en     = w_idle ? par_en    : r_par_en;
  assign w_cnt_base   = w_idle ? '0 : r_bit_cnt;
  assign w_cnt_inc    = w_cnt_base + CNT_W'(1);
  assign w_shreg_base = w_idle ? '0 : r_shreg;
  assign w_shreg_shift = w_msb ? {w_shreg_base[DATA_WIDTH-2:0], sampled_bit}
                               : {sampled_bit, w_shreg_base[DATA_WIDTH-1:1]};

  assign w_data_tick = w_tick && (w_idle || r_state == DATA);
  assign w_last      = w_data_tick && (w_cnt_inc == w_len);
  assign w_par_tick  = w_tick && (r_state == PARITY);
  assign w_fin_data  = w_last && !w_par_en;
  assign w_word_fin  = align(w_shreg_shift, w_len, w_msb);
  assign w_word_par  = align(r_shreg, r_len, r_msb);

  uart_par_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par_calc (
    .i_word     (w_word_par),
    .i_len      (r_len),
    .i_par_type (r_par_type),
    .o_par      (w_par_exp)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (deser_en) w_state_nxt = w_last ? (w_par_en ? PARITY : DONE) : DATA;
      DATA: begin
        if (!deser_en)   w_state_nxt = IDLE;
        else if (w_last) w_state_nxt = w_par_en ? PARITY : DONE;
      end
      PARITY: begin
        if (!deser_en)       w_state_nxt = IDLE;
        else if (w_par_tick) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_shreg    <= '0;
      r_pdata    <= '0;
      r_bit_cnt  <= '0;
      r_len      <= '0;
      r_msb      <= 1'b0;
      r_par_en   <= 1'b0;
      r_par_type <= PAR_EVEN;
      r_par_err  <= 1'b0;
    end else begin
      if (w_idle && deser_en) begin
        r_len      <= w_len_in;
        r_msb      <= msb_first;
        r_par_en   <= par_en;
        r_par_type <= par_type;
      end
      if (w_data_tick) begin
        r_shreg   <= w_shreg_shift;
        r_bit_cnt <= w_cnt_inc;
      end else if (w_idle && deser_en) begin
        r_shreg   <= '0;
        r_bit_cnt <= '0;
      end else if (!deser_en && (r_state == DATA || r_state == PARITY)) begin
        r_bit_cnt <= '0;
      end
      if (w_fin_data) begin
        r_pdata   <= w_word_fin;
        r_par_err <= 1'b0;
      end else if (w_par_tick) begin
        r_pdata   <= w_word_par;
        r_par_err <= (sampled_bit != w_par_exp);
      end
    end
  end

  assign P_DATA     = r_pdata;
  assign data_valid = (r_state == DONE);
  assign par_err    = r_par_err;
  assign busy       = (r_state != IDLE);
  assign bit_cnt    = r_bit_cnt;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: vector table, hand-written abort/reset sequences,
// and random frames scored against an arithmetic model of the frame format.
module tb_uart_rx_deserializer;

  logic       CLK = 1'b0;
  logic       RST, deser_en, sampled_bit;
  logic [4:0] edge_cnt, prescale;
  logic [3:0] data_len;
  logic       msb_first, par_en, par_type;
  logic [7:0] P_DATA;
  logic       data_valid, par_err, busy;
  logic [3:0] bit_cnt;

  int errors = 0;
  int checks = 0;
  int dv_seen = 0;

  always #5 CLK = ~CLK;

  uart_rx_deserializer #(.DATA_WIDTH(8), .EDGE_W(5)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .deser_en    (deser_en),
    .sampled_bit (sampled_bit),
    .edge_cnt    (edge_cnt),
    .prescale    (prescale),
    .data_len    (data_len),
    .msb_first   (msb_first),
    .par_en      (par_en),
    .par_type    (par_type),
    .P_DATA      (P_DATA),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .busy        (busy),
    .bit_cnt     (bit_cnt)
  );

  typedef struct {
    logic [4:0] pre;
    int         start;
    logic [3:0] dl;
    logic       msb;
    logic       pen;
    logic       ptype;
    logic [8:0] s;
    logic       pbit;
    logic [7:0] exp_d;
    logic       exp_e;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    if (data_valid === 1'b1) dv_seen++;
  endtask

  function automatic int eff_len(input logic [3:0] dl);
    return (dl == 4'd0 || dl > 4'd8) ? 8 : int'(dl);
  endfunction

  // Reference: stream bit i is the i-th bit on the line
  task automatic model(input logic [3:0] dl, input logic msb, input logic pen, input logic ptype,
                       input logic [8:0] s, input logic pbit,
                       output logic [7:0] d, output logic e);
    int len = eff_len(dl);
    int acc = 0;
    int ones = 0;
    for (int i = 0; i < len; i++) begin
      if (msb) acc = acc * 2 + int'(s[i]);
      else     acc = acc + (int'(s[i]) << i);
      ones += int'(s[i]);
    end
    d = 8'(acc);
    e = pen ? (pbit != (((ones % 2) == 1) ^ ptype)) : 1'b0;
  endtask

  task automatic do_frame(input string tag, input logic [4:0] pre, input int start,
                          input logic [3:0] dl, input logic msb, input logic pen, input logic ptype,
                          input logic [8:0] s, input logic pbit,
                          input logic [7:0] exp_d, input logic exp_e);
    int period = (pre == 5'd0) ? 32 : int'(pre);
    int nbits  = eff_len(dl) + (pen ? 1 : 0);
    int dv0    = dv_seen;
    prescale  = pre;
    data_len  = dl;
    msb_first = msb;
    par_en    = pen;
    par_type  = ptype;
    deser_en  = 1'b1;
    for (int b = 0; b < nbits; b++) begin
      sampled_bit = (b < eff_len(dl)) ? s[b] : pbit;
      for (int e = (b == 0) ? start : 0; e < period; e++) begin
        edge_cnt = 5'(e);
        step();
      end
      // configuration must stay latched from the start of the frame
      msb_first = ~msb;
      par_en    = ~pen;
      par_type  = ~ptype;
      data_len  = dl ^ 4'h5;
    end
    chk({tag, " data_valid"}, 32'(data_valid), 32'd1);
    chk({tag, " dv_count"}, 32'(dv_seen - dv0), 32'd1);
    chk({tag, " P_DATA"}, 32'(P_DATA), 32'(exp_d));
    chk({tag, " par_err"}, 32'(par_err), 32'(exp_e));
    chk({tag, " busy_done"}, 32'(busy), 32'd1);
    deser_en    = 1'b0;
    edge_cnt    = 5'd0;
    sampled_bit = 1'b1;
    step();
    chk({tag, " dv_low"}, 32'(data_valid), 32'd0);
    chk({tag, " busy_low"}, 32'(busy), 32'd0);
    chk({tag, " P_DATA_hold"}, 32'(P_DATA), 32'(exp_d));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[11];
    int   dv0;

    RST = 1'b1; deser_en = 1'b0; sampled_bit = 1'b1; edge_cnt = '0; prescale = 5'd8;
    data_len = 4'd8; msb_first = 1'b0; par_en = 1'b0; par_type = 1'b0;
    repeat (3) step();
    chk("reset P_DATA", 32'(P_DATA), 32'd0);
    chk("reset data_valid", 32'(data_valid), 32'd0);
    chk("reset par_err", 32'(par_err), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset bit_cnt", 32'(bit_cnt), 32'd0);
    RST = 1'b0;
    step();

    //            pre    start dl     msb   pen   ptype s        pbit  exp_d   exp_e
    tbl[0]  = '{5'd8, 0, 4'd8,  1'b0, 1'b0, 1'b0, 9'h0A5, 1'b0, 8'hA5, 1'b0};
    tbl[1]  = '{5'd8, 0, 4'd8,  1'b0, 1'b1, 1'b0, 9'h0A5, 1'b1, 8'hA5, 1'b1};
    tbl[2]  = '{5'd8, 0, 4'd8,  1'b0, 1'b1, 1'b0, 9'h0A5, 1'b0, 8'hA5, 1'b0};
    tbl[3]  = '{5'd8, 7, 4'd5,  1'b1, 1'b0, 1'b0, 9'h00D, 1'b0, 8'h16, 1'b0};
    tbl[4]  = '{5'd8, 0, 4'd0,  1'b0, 1'b0, 1'b0, 9'h03C, 1'b0, 8'h3C, 1'b0};
    tbl[5]  = '{5'd8, 0, 4'd12, 1'b0, 1'b0, 1'b0, 9'h05A, 1'b0, 8'h5A, 1'b0};
    tbl[6]  = '{5'd8, 0, 4'd8,  1'b0, 1'b1, 1'b1, 9'h03C, 1'b1, 8'h3C, 1'b0};
    tbl[7]  = '{5'd8, 0, 4'd8,  1'b1, 1'b1, 1'b1, 9'h083, 1'b1, 8'hC1, 1'b1};
    tbl[8]  = '{5'd8, 0, 4'd1,  1'b0, 1'b1, 1'b0, 9'h001, 1'b1, 8'h01, 1'b0};
    tbl[9]  = '{5'd0, 0, 4'd8,  1'b0, 1'b0, 1'b0, 9'h096, 1'b0, 8'h96, 1'b0};
    tbl[10] = '{5'd3, 0, 4'd5,  1'b0, 1'b0, 1'b0, 9'h1FB, 1'b0, 8'h1B, 1'b0};

    for (int i = 0; i < 11; i++) begin
      do_frame($sformatf("vec%0d", i), tbl[i].pre, tbl[i].start, tbl[i].dl, tbl[i].msb,
               tbl[i].pen, tbl[i].ptype, tbl[i].s, tbl[i].pbit, tbl[i].exp_d, tbl[i].exp_e);
    end

    // Abort after four data bits
    do_frame("pre_abort", 5'd8, 0, 4'd8, 1'b0, 1'b0, 1'b0, 9'h0A5, 1'b0, 8'hA5, 1'b0);
    dv0 = dv_seen;
    prescale = 5'd8; data_len = 4'd8; msb_first = 1'b0; par_en = 1'b0;
    deser_en = 1'b1; sampled_bit = 1'b0;
    for (int b = 0; b < 4; b++)
      for (int e = 0; e < 8; e++) begin edge_cnt = 5'(e); step(); end
    chk("abort busy_before", 32'(busy), 32'd1);
    chk("abort bit_cnt_before", 32'(bit_cnt), 32'd4);
    deser_en = 1'b0; edge_cnt = 5'd0;
    step();
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort bit_cnt", 32'(bit_cnt), 32'd0);
    chk("abort data_valid", 32'(data_valid), 32'd0);
    chk("abort P_DATA", 32'(P_DATA), 32'hA5);

    // deser_en falling on the final tick gates it
    deser_en = 1'b1; sampled_bit = 1'b0;
    for (int b = 0; b < 7; b++)
      for (int e = 0; e < 8; e++) begin edge_cnt = 5'(e); step(); end
    for (int e = 0; e < 7; e++) begin edge_cnt = 5'(e); step(); end
    chk("gated bit_cnt_before", 32'(bit_cnt), 32'd7);
    edge_cnt = 5'd7; deser_en = 1'b0;
    step();
    chk("gated busy", 32'(busy), 32'd0);
    chk("gated bit_cnt", 32'(bit_cnt), 32'd0);
    step();
    chk("gated P_DATA", 32'(P_DATA), 32'hA5);
    chk("abort dv_count", 32'(dv_seen - dv0), 32'd0);

    // Reset during bit 3
    do_frame("pre_rst", 5'd8, 0, 4'd8, 1'b0, 1'b1, 1'b0, 9'h0A5, 1'b1, 8'hA5, 1'b1);
    prescale = 5'd8; data_len = 4'd8; msb_first = 1'b0; par_en = 1'b0;
    deser_en = 1'b1; sampled_bit = 1'b1;
    for (int b = 0; b < 3; b++)
      for (int e = 0; e < 8; e++) begin edge_cnt = 5'(e); step(); end
    for (int e = 0; e < 3; e++) begin edge_cnt = 5'(e); step(); end
    chk("rst bit_cnt_before", 32'(bit_cnt), 32'd3);
    edge_cnt = 5'd3; RST = 1'b1;
    step();
    chk("rst P_DATA", 32'(P_DATA), 32'd0);
    chk("rst par_err", 32'(par_err), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst bit_cnt", 32'(bit_cnt), 32'd0);
    chk("rst data_valid", 32'(data_valid), 32'd0);
    RST = 1'b0; deser_en = 1'b0; edge_cnt = 5'd0;
    step();
    do_frame("post_rst", 5'd8, 0, 4'd8, 1'b0, 1'b0, 1'b0, 9'h03C, 1'b0, 8'h3C, 1'b0);

    // Random frames against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [4:0] pre;
      logic [3:0] dl;
      logic       msb, pen, ptype, pbit;
      logic [8:0] s;
      logic [7:0] ed;
      logic       ee;
      int         start;
      pre   = 5'($urandom_range(2, 9));
      dl    = 4'($urandom_range(0, 15));
      msb   = 1'($urandom);
      pen   = 1'($urandom);
      ptype = 1'($urandom);
      pbit  = 1'($urandom);
      s     = 9'($urandom);
      start = int'($urandom_range(0, int'(pre) - 1));
      model(dl, msb, pen, ptype, s, pbit, ed, ee);
      do_frame($sformatf("rnd%0d", n), pre, start, dl, msb, pen, ptype, s, pbit, ed, ee);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
